// File: rtl/rht_rollback_ctrl.sv
// Rename History Table rollback controller.
// On a flush it walks the RHT from the current tail back to the flush point,
// youngest entry first, handing each undone (Ldst, Pdst) mapping to the
// RAT/free-list consumer over a valid/ready handshake. When the walk ends it
// pulses set_ptr so the RHT tail is reloaded with the flush point.
module rht_rollback_ctrl #(
  parameter  int RHT_DEPTH    = 128,
  parameter  int L_ADDR_WIDTH = 5,
  parameter  int P_ADDR_WIDTH = 8,
  localparam int IW           = $clog2(RHT_DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  // flush request and RHT pointers
  input  logic                    flush_req,
  input  logic [IW-1:0]           flush_ptr,
  input  logic [IW-1:0]           rht_tail,
  // RHT read port
  output logic [IW-1:0]           rd_id,
  input  logic [L_ADDR_WIDTH-1:0] rd_Ldst,
  input  logic [P_ADDR_WIDTH-1:0] rd_Pdst,
  // restore stream to RAT / free list
  output logic                    restore_valid,
  input  logic                    restore_ready,
  output logic [L_ADDR_WIDTH-1:0] restore_Ldst,
  output logic [P_ADDR_WIDTH-1:0] restore_Pdst,
  // tail reload
  output logic                    set_ptr,
  output logic [IW-1:0]           new_pointer,
  // status
  output logic                    busy,
  output logic [IW:0]             walk_count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WALK = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Highest valid RHT index; the walk wraps to it after index 0, which keeps
  // non-power-of-two depths correct.
  localparam logic [IW-1:0] LAST_IDX = IW'(RHT_DEPTH - 1);

  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;
  logic [IW-1:0] r_cur;        // oldest entry already undone (tail at start)
  logic [IW-1:0] w_cur_nxt;
  logic [IW-1:0] r_target;     // index to stop at, becomes the new tail
  logic [IW-1:0] w_target_nxt;
  logic [IW:0]   r_walk_count;
  logic [IW:0]   w_walk_count_nxt;

  logic [IW-1:0] w_eff_target; // target as seen this cycle, including a re-flush
  logic          w_stop_here;  // re-flush lands on cur: nothing left to undo
  logic          w_beat_fire;

  // Next entry to undo: one step older than cur, wrapping below zero.
  assign rd_id = (r_cur == '0) ? LAST_IDX : r_cur - IW'(1);

  assign w_eff_target = (r_state == S_WALK && flush_req) ? flush_ptr : r_target;
  // The current beat is withdrawn when a re-flush moves the target onto cur,
  // so the consumer never sees an entry that lies past the new flush point.
  assign w_stop_here  = (r_state == S_WALK) && flush_req && (flush_ptr == r_cur);

  assign restore_valid = (r_state == S_WALK) && !w_stop_here;
  assign restore_Ldst  = rd_Ldst;
  assign restore_Pdst  = rd_Pdst;
  assign w_beat_fire   = restore_valid && restore_ready;

  assign set_ptr     = (r_state == S_DONE);
  assign new_pointer = (r_state == S_DONE) ? r_target : '0;
  assign busy        = (r_state != S_IDLE);
  assign walk_count  = r_walk_count;

  // Next-state logic for the walk FSM and its datapath registers.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // one unassigned; an unassigned path would infer a latch.
    w_state_nxt      = r_state;
    w_cur_nxt        = r_cur;
    w_target_nxt     = r_target;
    w_walk_count_nxt = r_walk_count;

    case (r_state)
      S_IDLE: begin
        if (flush_req) begin
          w_cur_nxt        = rht_tail;
          w_target_nxt     = flush_ptr;
          w_walk_count_nxt = '0;
          w_state_nxt      = (flush_ptr != rht_tail) ? S_WALK : S_DONE;
        end
      end

      S_WALK: begin
        w_target_nxt = w_eff_target;
        if (w_stop_here) begin
          w_state_nxt = S_DONE;
        end else if (w_beat_fire) begin
          w_cur_nxt        = rd_id;
          w_walk_count_nxt = r_walk_count + (IW+1)'(1);
          if (rd_id == w_eff_target) begin
            w_state_nxt = S_DONE;
          end
        end
      end

      S_DONE: begin
        // A flush arriving here is dropped; the pending set_ptr completes.
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State registers; reset aborts any walk without a set_ptr pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cur        <= '0;
      r_target     <= '0;
      r_walk_count <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_cur        <= w_cur_nxt;
      r_target     <= w_target_nxt;
      r_walk_count <= w_walk_count_nxt;
    end
  end

endmodule

// File: tb/tb_rht_rollback_ctrl.sv
// Self-checking bench for rht_rollback_ctrl. A queue-based reference model
// lists the indices still to be undone and predicts every output each cycle;
// directed flush scenarios are followed by randomized traffic.
module tb_rht_rollback_ctrl;

  localparam int D  = 128;
  localparam int LW = 5;
  localparam int PW = 8;
  localparam int IW = $clog2(D);

  logic          clk;
  logic          rst_n;
  logic          flush_req;
  logic [IW-1:0] flush_ptr;
  logic [IW-1:0] rht_tail;
  logic [IW-1:0] rd_id;
  logic [LW-1:0] rd_Ldst;
  logic [PW-1:0] rd_Pdst;
  logic          restore_valid;
  logic          restore_ready;
  logic [LW-1:0] restore_Ldst;
  logic [PW-1:0] restore_Pdst;
  logic          set_ptr;
  logic [IW-1:0] new_pointer;
  logic          busy;
  logic [IW:0]   walk_count;

  // RHT contents, read combinationally at rd_id
  logic [LW-1:0] mem_l [D];
  logic [PW-1:0] mem_p [D];
  assign rd_Ldst = mem_l[rd_id];
  assign rd_Pdst = mem_p[rd_id];

  rht_rollback_ctrl #(
    .RHT_DEPTH    (D),
    .L_ADDR_WIDTH (LW),
    .P_ADDR_WIDTH (PW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush_req     (flush_req),
    .flush_ptr     (flush_ptr),
    .rht_tail      (rht_tail),
    .rd_id         (rd_id),
    .rd_Ldst       (rd_Ldst),
    .rd_Pdst       (rd_Pdst),
    .restore_valid (restore_valid),
    .restore_ready (restore_ready),
    .restore_Ldst  (restore_Ldst),
    .restore_Pdst  (restore_Pdst),
    .set_ptr       (set_ptr),
    .new_pointer   (new_pointer),
    .busy          (busy),
    .walk_count    (walk_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit m_walk;     // rollback walk in progress
  bit m_done;     // tail reload due this cycle
  int m_pos;      // last position reached (tail or last undone index)
  int m_target;
  int m_count;
  int m_q[$];     // indices still to undo, youngest first

  function automatic void build_path(input int from, input int to);
    int idx;
    m_q.delete();
    idx = from;
    while (idx != to) begin
      idx = (idx + D - 1) % D;
      m_q.push_back(idx);
    end
  endfunction

  function automatic void model_reset();
    m_walk = 0; m_done = 0; m_pos = 0; m_target = 0; m_count = 0;
    m_q.delete();
  endfunction

  // Drive one cycle of inputs, compare outputs mid-cycle, advance model.
  task automatic step(input logic fr, input int fp, input int tl, input logic rdy);
    bit exp_valid;
    int beat;
    flush_req     = fr;
    flush_ptr     = IW'(fp);
    rht_tail      = IW'(tl);
    restore_ready = rdy;
    if (m_walk && fr) begin
      m_target = fp;
      build_path(m_pos, fp);
    end
    exp_valid = m_walk && (m_q.size() > 0);
    #1;
    check("busy", busy, m_walk || m_done);
    check("restore_valid", restore_valid, exp_valid);
    check("set_ptr", set_ptr, m_done);
    check("walk_count", walk_count, m_count);
    if (m_done) check("new_pointer", new_pointer, m_target);
    if (exp_valid) begin
      beat = m_q[0];
      check("rd_id", rd_id, beat);
      check("restore_Ldst", restore_Ldst, mem_l[beat]);
      check("restore_Pdst", restore_Pdst, mem_p[beat]);
    end
    // state advance at the coming clock edge
    if (m_done) begin
      m_done = 0;
    end else if (m_walk) begin
      if (m_q.size() == 0) begin
        m_walk = 0; m_done = 1;
      end else if (rdy) begin
        m_pos = m_q.pop_front();
        m_count++;
        if (m_q.size() == 0) begin
          m_walk = 0; m_done = 1;
        end
      end
    end else if (fr) begin
      m_pos = tl; m_target = fp; m_count = 0;
      build_path(tl, fp);
      if (m_q.size() == 0) m_done = 1;
      else                 m_walk = 1;
    end
    @(negedge clk);
  endtask

  // Asynchronous reset in the middle of a cycle; outputs must clear at once.
  task automatic mid_reset();
    flush_req = 1'b0;
    restore_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_valid", restore_valid, 0);
    check("rst_set_ptr", set_ptr, 0);
    check("rst_new_pointer", new_pointer, 0);
    check("rst_walk_count", walk_count, 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Directed flush: optional stall, re-flush and reset keyed on beat number.
  task automatic run_scn(input int tl, input int fp, input int stall_beat, input int stall_len,
                         input int rf_beat, input int rf_ptr, input int rst_beat,
                         input int exp_wc);
    int   stalled;
    bit   rf_done;
    int   cyc;
    logic fr;
    int   p;
    logic rdy;
    stalled = 0; rf_done = 0; cyc = 0;
    step(1'b1, fp, tl, 1'b1);
    while ((m_walk || m_done) && cyc < 200) begin
      fr = 1'b0; p = 0; rdy = 1'b1;
      if (m_walk && m_count == stall_beat && stalled < stall_len) begin
        rdy = 1'b0; stalled++;
      end
      if (m_walk && m_count == rf_beat && !rf_done) begin
        fr = 1'b1; p = rf_ptr; rf_done = 1;
      end
      if (m_walk && m_count == rst_beat) begin
        mid_reset();
        break;
      end
      step(fr, p, $urandom_range(0, D-1), rdy);
      cyc++;
    end
    if (cyc >= 200) check("scn_timeout", 1, 0);
    if (exp_wc >= 0) check("scn_walk_count", walk_count, exp_wc);
  endtask

  initial begin
    int fp, d, k;
    logic fr;
    for (int i = 0; i < D; i++) begin
      mem_l[i] = LW'($urandom);
      mem_p[i] = PW'($urandom);
    end
    rst_n = 1'b0; flush_req = 1'b0; flush_ptr = '0; rht_tail = '0; restore_ready = 1'b0;
    model_reset();
    #1;
    check("reset_busy", busy, 0);
    check("reset_valid", restore_valid, 0);
    check("reset_set_ptr", set_ptr, 0);
    check("reset_new_pointer", new_pointer, 0);
    check("reset_walk_count", walk_count, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // simple walk, wrap walk, empty walk
    run_scn(10, 6, -1, 0, -1, 0, -1, 4);
    run_scn(2, 126, -1, 0, -1, 0, -1, 4);
    run_scn(40, 40, -1, 0, -1, 0, -1, 0);
    // stall on second beat, then re-flush on third beat
    run_scn(20, 15, 1, 3, -1, 0, -1, 5);
    run_scn(30, 20, -1, 0, 2, 12, -1, 18);
    // re-flush onto the position already reached: no further beats
    run_scn(50, 40, -1, 0, 3, 47, -1, 3);
    // reset during beat 2 of 6, then a fresh walk
    run_scn(70, 64, -1, 0, -1, 0, 1, 0);
    run_scn(5, 1, -1, 0, -1, 0, -1, 4);
    // flush in the reload cycle is ignored; walk_count holds in idle
    step(1'b1, 100, 110, 1'b1);
    while (m_walk) step(1'b0, 0, 0, 1'b1);
    step(1'b1, 3, 9, 1'b1);
    step(1'b0, 0, 0, 1'b1);
    step(1'b0, 0, 0, 1'b1);
    check("wc_hold", walk_count, 10);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      fr = 1'b0; fp = 0;
      if (!m_walk && !m_done) begin
        fr = ($urandom_range(0, 2) == 0);
        k  = $urandom_range(0, 12);
        d  = $urandom_range(0, D-1);
        fp = (d + D - k) % D;
        step(fr, fp, d, $urandom_range(0, 3) != 0);
      end else begin
        if (m_walk && $urandom_range(0, 9) == 0) begin
          d  = (m_pos - m_target + D) % D + 4;
          if (d > D - 2) d = D - 2;
          fr = 1'b1;
          fp = (m_pos + D - $urandom_range(0, d)) % D;
        end else if (m_done) begin
          fr = $urandom_range(0, 1);
          fp = $urandom_range(0, D-1);
        end
        step(fr, fp, $urandom_range(0, D-1), $urandom_range(0, 3) != 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
